// File: rtl/avalon_mm_arbiter_2x1.sv
// Two-requester round-robin arbiter onto one Avalon-MM host port.
// Transfers that stall past a waitrequest timeout are aborted with SLAVEERROR.
module avalon_mm_arbiter_2x1 #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BYTEENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [ADDR_WIDTH-1:0]       s0_avalon_mm_address,
  input  logic [BYTEENABLE_WIDTH-1:0] s0_avalon_mm_byteenable,
  input  logic                        s0_avalon_mm_read,
  input  logic                        s0_avalon_mm_write,
  input  logic [DATA_WIDTH-1:0]       s0_avalon_mm_writedata,
  output logic [DATA_WIDTH-1:0]       s0_avalon_mm_readdata,
  output logic [1:0]                  s0_avalon_mm_response,
  output logic                        s0_avalon_mm_waitrequest,

  input  logic [ADDR_WIDTH-1:0]       s1_avalon_mm_address,
  input  logic [BYTEENABLE_WIDTH-1:0] s1_avalon_mm_byteenable,
  input  logic                        s1_avalon_mm_read,
  input  logic                        s1_avalon_mm_write,
  input  logic [DATA_WIDTH-1:0]       s1_avalon_mm_writedata,
  output logic [DATA_WIDTH-1:0]       s1_avalon_mm_readdata,
  output logic [1:0]                  s1_avalon_mm_response,
  output logic                        s1_avalon_mm_waitrequest,

  output logic [ADDR_WIDTH-1:0]       h_avalon_mm_address,
  output logic [BYTEENABLE_WIDTH-1:0] h_avalon_mm_byteenable,
  output logic                        h_avalon_mm_read,
  output logic                        h_avalon_mm_write,
  output logic [DATA_WIDTH-1:0]       h_avalon_mm_writedata,
  input  logic [DATA_WIDTH-1:0]       h_avalon_mm_readdata,
  input  logic [1:0]                  h_avalon_mm_response,
  input  logic                        h_avalon_mm_waitrequest,

  output logic                        timeout_event
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] TimeoutLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic            last_q, last_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic req0, req1;
  assign req0 = s0_avalon_mm_read | s0_avalon_mm_write;
  assign req1 = s1_avalon_mm_read | s1_avalon_mm_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;  // port 0 wins the first tie
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d    = StGrant;
          sel_d      = (req0 && req1) ? ~last_q : req1;
          wait_cnt_d = '0;
        end
      end
      StGrant: begin
        // Completion takes priority over the timeout threshold.
        if (!h_avalon_mm_waitrequest) begin
          last_d  = sel_q;
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == TimeoutLast) begin
          state_d = StAbort;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StAbort: begin
        last_d  = sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    h_avalon_mm_address      = '0;
    h_avalon_mm_byteenable   = '0;
    h_avalon_mm_read         = 1'b0;
    h_avalon_mm_write        = 1'b0;
    h_avalon_mm_writedata    = '0;
    s0_avalon_mm_readdata    = '0;
    s0_avalon_mm_response    = 2'b00;
    s0_avalon_mm_waitrequest = 1'b1;
    s1_avalon_mm_readdata    = '0;
    s1_avalon_mm_response    = 2'b00;
    s1_avalon_mm_waitrequest = 1'b1;
    timeout_event            = 1'b0;
    unique case (state_q)
      StGrant: begin
        if (!sel_q) begin
          h_avalon_mm_address      = s0_avalon_mm_address;
          h_avalon_mm_byteenable   = s0_avalon_mm_byteenable;
          h_avalon_mm_read         = s0_avalon_mm_read;
          h_avalon_mm_write        = s0_avalon_mm_write;
          h_avalon_mm_writedata    = s0_avalon_mm_writedata;
          s0_avalon_mm_readdata    = h_avalon_mm_readdata;
          s0_avalon_mm_response    = h_avalon_mm_response;
          s0_avalon_mm_waitrequest = h_avalon_mm_waitrequest;
        end else begin
          h_avalon_mm_address      = s1_avalon_mm_address;
          h_avalon_mm_byteenable   = s1_avalon_mm_byteenable;
          h_avalon_mm_read         = s1_avalon_mm_read;
          h_avalon_mm_write        = s1_avalon_mm_write;
          h_avalon_mm_writedata    = s1_avalon_mm_writedata;
          s1_avalon_mm_readdata    = h_avalon_mm_readdata;
          s1_avalon_mm_response    = h_avalon_mm_response;
          s1_avalon_mm_waitrequest = h_avalon_mm_waitrequest;
        end
      end
      StAbort: begin
        timeout_event = 1'b1;
        if (!sel_q) begin
          s0_avalon_mm_readdata    = '1;
          s0_avalon_mm_response    = 2'b10;
          s0_avalon_mm_waitrequest = 1'b0;
        end else begin
          s1_avalon_mm_readdata    = '1;
          s1_avalon_mm_response    = 2'b10;
          s1_avalon_mm_waitrequest = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avalon_mm_arbiter_2x1.sv
// Directed bench for avalon_mm_arbiter_2x1 with an 8-cycle timeout.
module tb_avalon_mm_arbiter_2x1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_address, s1_address, s0_writedata, s1_writedata;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_readdata, s1_readdata;
  logic [1:0]  s0_response, s1_response;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] h_address, h_writedata, h_readdata;
  logic [3:0]  h_byteenable;
  logic        h_read, h_write, h_waitrequest;
  logic [1:0]  h_response;
  logic        timeout_event;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_mm_arbiter_2x1 #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTEENABLE_WIDTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s0_avalon_mm_address     (s0_address),
    .s0_avalon_mm_byteenable  (s0_byteenable),
    .s0_avalon_mm_read        (s0_read),
    .s0_avalon_mm_write       (s0_write),
    .s0_avalon_mm_writedata   (s0_writedata),
    .s0_avalon_mm_readdata    (s0_readdata),
    .s0_avalon_mm_response    (s0_response),
    .s0_avalon_mm_waitrequest (s0_waitrequest),
    .s1_avalon_mm_address     (s1_address),
    .s1_avalon_mm_byteenable  (s1_byteenable),
    .s1_avalon_mm_read        (s1_read),
    .s1_avalon_mm_write       (s1_write),
    .s1_avalon_mm_writedata   (s1_writedata),
    .s1_avalon_mm_readdata    (s1_readdata),
    .s1_avalon_mm_response    (s1_response),
    .s1_avalon_mm_waitrequest (s1_waitrequest),
    .h_avalon_mm_address      (h_address),
    .h_avalon_mm_byteenable   (h_byteenable),
    .h_avalon_mm_read         (h_read),
    .h_avalon_mm_write        (h_write),
    .h_avalon_mm_writedata    (h_writedata),
    .h_avalon_mm_readdata     (h_readdata),
    .h_avalon_mm_response     (h_response),
    .h_avalon_mm_waitrequest  (h_waitrequest),
    .timeout_event            (timeout_event)
  );

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    s0_address = 0; s1_address = 0; s0_writedata = 0; s1_writedata = 0;
    s0_byteenable = 0; s1_byteenable = 0;
    h_waitrequest = 0; h_readdata = 0; h_response = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    s0_read = 1; s1_write = 1; s1_writedata = 32'hDEAD_BEEF;
    h_readdata = 32'h1111_2222; h_response = 2'b11;
    next_cycle(); #1;
    checks++;
    if ({h_read, h_write, s0_waitrequest, s1_waitrequest, timeout_event} !== 5'b00110) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00110",
               {h_read, h_write, s0_waitrequest, s1_waitrequest, timeout_event});
    end
    checks++;
    if ({h_address, h_writedata, h_byteenable, s0_readdata, s1_readdata, s0_response,
         s1_response} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h be=%h rd0=%h rd1=%h r0=%b r1=%b want zeros",
               h_address, h_writedata, h_byteenable, s0_readdata, s1_readdata,
               s0_response, s1_response);
    end
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read();
    s0_read = 1; s0_address = 32'h0000_0010; s0_byteenable = 4'hF;
    h_readdata = 32'hCAFE_BABE; h_response = 2'b00; h_waitrequest = 0;
    #1;
    checks++;
    if ({h_read, s0_waitrequest, s1_waitrequest} !== 3'b011) begin
      errors++;
      $display("FAIL read_arb got %b want 011", {h_read, s0_waitrequest, s1_waitrequest});
    end
    next_cycle(); #1;
    checks++;
    if ({h_read, h_write, s0_waitrequest, s1_waitrequest} !== 4'b1001 ||
        h_address !== 32'h10 || s0_readdata !== 32'hCAFE_BABE || s0_response !== 2'b00) begin
      errors++;
      $display("FAIL read_done got ctl=%b addr=%h rd=%h resp=%b want 1001 10 cafebabe 00",
               {h_read, h_write, s0_waitrequest, s1_waitrequest}, h_address, s0_readdata,
               s0_response);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if ({h_read, s0_waitrequest, s1_waitrequest} !== 3'b011) begin
      errors++;
      $display("FAIL read_after got %b want 011", {h_read, s0_waitrequest, s1_waitrequest});
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic        exp_w, exp_sel;
    logic [31:0] exp_d;
    rst = 1'b1; #1; rst = 1'b0;  // restore last=1 so port 0 wins the first tie
    s0_write = 1; s0_writedata = 32'hAAAA_0000; s0_byteenable = 4'hF;
    s1_write = 1; s1_writedata = 32'hBBBB_1111; s1_byteenable = 4'hF;
    h_waitrequest = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_w   = (i % 2) == 1;
      exp_sel = ((i / 2) % 2) == 1;
      exp_d   = !exp_w ? 32'h0 : (exp_sel ? 32'hBBBB_1111 : 32'hAAAA_0000);
      checks++;
      if (h_write !== exp_w || h_writedata !== exp_d ||
          s0_waitrequest !== !(exp_w && !exp_sel) ||
          s1_waitrequest !== !(exp_w && exp_sel)) begin
        errors++;
        $display("FAIL rr_cycle%0d got w=%b d=%h wr0=%b wr1=%b want w=%b d=%h wr0=%b wr1=%b",
                 i, h_write, h_writedata, s0_waitrequest, s1_waitrequest, exp_w, exp_d,
                 !(exp_w && !exp_sel), !(exp_w && exp_sel));
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_wait_states();
    s1_write = 1; s1_writedata = 32'h1234_5678; s1_byteenable = 4'b0011;
    s1_address = 32'h0000_0040; h_waitrequest = 1;
    next_cycle();
    for (int g = 0; g < 6; g++) begin
      h_waitrequest = (g < 5);
      #1;
      checks++;
      if (h_write !== 1'b1 || h_writedata !== 32'h1234_5678 || h_byteenable !== 4'b0011 ||
          h_address !== 32'h40 || s1_waitrequest !== (g < 5) || s0_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL ws_cycle%0d got w=%b d=%h be=%b a=%h wr1=%b wr0=%b want 1 12345678 0011 40 %b 1",
                 g, h_write, h_writedata, h_byteenable, h_address, s1_waitrequest,
                 s0_waitrequest, (g < 5));
      end
      next_cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (h_write !== 1'b0 || s1_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL ws_after got w=%b wr1=%b want 0 1", h_write, s1_waitrequest);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    s0_read = 1; s0_address = 32'h0000_0080; s0_byteenable = 4'hF;
    h_waitrequest = 1; h_readdata = 32'h0BAD_F00D; h_response = 2'b00;
    next_cycle();
    for (int g = 0; g < 8; g++) begin
      #1;
      checks++;
      if ({h_read, s0_waitrequest, timeout_event} !== 3'b110) begin
        errors++;
        $display("FAIL to_grant%0d got %b want 110", g, {h_read, s0_waitrequest, timeout_event});
      end
      next_cycle();
    end
    #1;
    checks++;
    if ({h_read, s0_waitrequest, timeout_event, s1_waitrequest} !== 4'b0011 ||
        s0_response !== 2'b10 || s0_readdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL to_abort got ctl=%b resp=%b rd=%h want 0011 10 ffffffff",
               {h_read, s0_waitrequest, timeout_event, s1_waitrequest}, s0_response,
               s0_readdata);
    end
    next_cycle();
    idle_inputs();
    s1_read = 1; s1_address = 32'h0000_00C0; h_readdata = 32'h7777_8888;
    #1;
    checks++;
    if ({h_read, timeout_event} !== 2'b00) begin
      errors++;
      $display("FAIL to_after got rd=%b te=%b want 0 0", h_read, timeout_event);
    end
    next_cycle(); #1;
    checks++;
    if ({h_read, s1_waitrequest, s0_waitrequest} !== 3'b101 || s1_readdata !== 32'h7777_8888) begin
      errors++;
      $display("FAIL to_next_grant got ctl=%b rd=%h want 101 77778888",
               {h_read, s1_waitrequest, s0_waitrequest}, s1_readdata);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_threshold();
    s0_read = 1; s0_address = 32'h0000_0100; s0_byteenable = 4'hF;
    h_waitrequest = 1; h_readdata = 32'h5A5A_A5A5; h_response = 2'b11;
    next_cycle();
    for (int g = 0; g < 7; g++) next_cycle();
    h_waitrequest = 0;
    #1;
    checks++;
    if ({h_read, s0_waitrequest, timeout_event} !== 3'b100 || s0_response !== 2'b11 ||
        s0_readdata !== 32'h5A5A_A5A5) begin
      errors++;
      $display("FAIL th_done got ctl=%b resp=%b rd=%h want 100 11 5a5aa5a5",
               {h_read, s0_waitrequest, timeout_event}, s0_response, s0_readdata);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if ({h_read, timeout_event, s0_waitrequest} !== 3'b001) begin
      errors++;
      $display("FAIL th_after got %b want 001", {h_read, timeout_event, s0_waitrequest});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    s1_write = 1; s1_writedata = 32'h0F0F_0F0F; s1_byteenable = 4'hF;
    h_waitrequest = 1; h_readdata = 32'h3333_4444; h_response = 2'b01;
    next_cycle(); #1;
    checks++;
    if (h_write !== 1'b1) begin
      errors++;
      $display("FAIL rm_grant got w=%b want 1", h_write);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if ({h_read, h_write, s0_waitrequest, s1_waitrequest, timeout_event} !== 5'b00110 ||
        h_writedata !== 32'h0 || s1_readdata !== 32'h0 || s1_response !== 2'b00) begin
      errors++;
      $display("FAIL rm_reset got ctl=%b wd=%h rd1=%h r1=%b want 00110 0 0 00",
               {h_read, h_write, s0_waitrequest, s1_waitrequest, timeout_event}, h_writedata,
               s1_readdata, s1_response);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    s0_read = 1; s1_read = 1; h_readdata = 32'h9999_0000;
    next_cycle(); #1;
    checks++;
    if ({h_read, s0_waitrequest, s1_waitrequest} !== 3'b101 || s0_readdata !== 32'h9999_0000) begin
      errors++;
      $display("FAIL rm_tie got ctl=%b rd0=%h want 101 99990000",
               {h_read, s0_waitrequest, s1_waitrequest}, s0_readdata);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_threshold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_mm_arbiter_2x1.md
# avalon_mm_arbiter_2x1

Two-requester round-robin arbiter sharing a single Avalon-MM host port, with a per-transfer waitrequest timeout. It sits between two Avalon-MM hosts (e.g. the XFCP Avalon-MM bridge and a local CPU or DMA) and one downstream Avalon-MM agent or interconnect. Transfers are single-word, waitrequest-flow-controlled, with no readdatavalid. Read data and response are valid in the completion cycle.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BYTEENABLE_WIDTH, DATA_WIDTH/8, byteenable width.
- TIMEOUT_CYCLES, 1024, number of waitrequest-high cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- sN_avalon_mm_address  in  ADDR_WIDTH  requester N (N = 0, 1) address.
- sN_avalon_mm_byteenable  in  BYTEENABLE_WIDTH  byte enables.
- sN_avalon_mm_read  in  1  read request.
- sN_avalon_mm_write  in  1  write request.
- sN_avalon_mm_writedata  in  DATA_WIDTH  write data.
- sN_avalon_mm_readdata  out  DATA_WIDTH  read data; valid when sN_waitrequest=0.
- sN_avalon_mm_response  out  2  response; valid when sN_waitrequest=0.
- sN_avalon_mm_waitrequest  out  1  stall; low only in sN's completion cycle.
- h_avalon_mm_address / byteenable / read / write / writedata  out  (widths as above)  downstream request.
- h_avalon_mm_readdata  in  DATA_WIDTH; h_avalon_mm_response  in  2; h_avalon_mm_waitrequest  in  1.
- timeout_event  out  1  one-cycle pulse on abort.

## Operation
- States: IDLE, GRANT, ABORT. Registers: state, sel (granted port), last (last granted port), wait_cnt.
- Request on port N: sN_read | sN_write.
- IDLE:
  - If only one port requests, grant it.
  - If both request, grant !last.
  - On grant: next state GRANT, sel <= winner, wait_cnt <= 0.
  - With no request, stay in IDLE.
- GRANT:
  - h_* request outputs are a combinational mux of the s[sel] inputs.
  - s[sel]_waitrequest = h_waitrequest.
  - s[sel]_readdata and s[sel]_response = h_readdata and h_response.
  - Non-granted port: waitrequest=1, readdata=0, response=0.
  - If h_waitrequest=0: transfer completes, last <= sel, next state IDLE.
  - Else if TIMEOUT_CYCLES≠0 and wait_cnt==TIMEOUT_CYCLES-1: next state ABORT.
  - Else wait_cnt++.
- ABORT (one cycle):
  - h_read=h_write=0.
  - s[sel]_waitrequest=0, s[sel]_response=2'b10 (SLAVEERROR), s[sel]_readdata all ones.
  - timeout_event=1; last <= sel; next state IDLE.
- Outside GRANT: h_read=h_write=0, h_address/byteenable/writedata=0, both sN_waitrequest=1.
- A requester asserting read and write together is illegal. Both are forwarded unchanged; the arbiter does no checking.
- A requester must hold its request and all qualifiers stable until it sees waitrequest low (Avalon rule). The arbiter does not latch them.
- The granted requester dropping its request while in GRANT is a protocol violation. The arbiter stays in GRANT and relies on the timeout to recover.
- wait_cnt width: clog2(TIMEOUT_CYCLES)+1; it saturates and never wraps.

## Timing
- Reset (asynchronous assert) sets state=IDLE, last=1 (so port 0 wins the first tie), sel=0, wait_cnt=0.
  - Outputs in reset: h_read=h_write=0, h_address/byteenable/writedata=0, sN_waitrequest=1, sN_readdata=0, sN_response=0, timeout_event=0.
- Reset asserted mid-transfer drops h_read/h_write immediately (combinational from state). No completion is signalled to the requester.
- Grant latency: request seen in IDLE at cycle T, so h_read/h_write is asserted at T+1.
- Minimum transfer is 2 cycles (one IDLE arbitration cycle and one GRANT cycle with h_waitrequest=0). Back-to-back transfers always pass through IDLE for one cycle.
- Abort timing: the GRANT cycles with h_waitrequest=1 are counted 0..TIMEOUT_CYCLES-1. ABORT is the next cycle, so completion comes TIMEOUT_CYCLES+1 cycles after grant.
- Completion and timeout threshold in the same cycle: h_waitrequest=0 wins, giving a normal completion.
- Both ports continuously requesting: grants strictly alternate 0,1,0,1… with one IDLE cycle between them.

## Test plan
- Single read: port 0 reads 0x0000_0010 and the agent returns 0xCAFEBABE with waitrequest low on the first cycle. Required: h_read high for exactly 1 cycle; s0_readdata=0xCAFEBABE with response 2'b00 in that cycle; s1_waitrequest high throughout.
- Tie and round-robin: both ports write continuously starting after reset with a zero-wait agent. Required: grant order 0,1,0,1; one h_write pulse every 2 cycles; port 1's writedata appears only on its grants.
- Wait states: the agent holds waitrequest for 5 cycles on a port 1 write of 0x1234_5678 with byteenable 4'b0011. Required: h_write held for 6 cycles with stable data; s1_waitrequest low only in the 6th.
- Timeout: TIMEOUT_CYCLES=8 and the agent never deasserts waitrequest on a port 0 read. Required: h_read high for 8 cycles then low; s0 gets response 2'b10 and readdata 0xFFFFFFFF; timeout_event pulses once; the next port 1 request is then granted.
- Threshold collision: TIMEOUT_CYCLES=8 and h_waitrequest drops in the 8th GRANT cycle. Required: normal completion with the agent's response, no timeout_event.
- Reset mid-transfer: assert rst during a port 1 wait state. Required: h_write falls in the same cycle; all outputs take their reset values; after release, port 0 wins the first tie.
